// File: rtl/vid_cap_pkg.sv
// Shared types and constants for the video capture block: capture state
// encoding, default frame geometry and the CRC-16-CCITT helper used when
// VID_CAPTURE_CRC_EN is defined.
package vid_cap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        WAIT_VIS,
        ACTIVE,
        FLUSH
    } cap_state_t;

    localparam int H_ACTIVE_DEF = 336;
    localparam int V_ACTIVE_DEF = 240;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One 16-bit word folded into the CRC, most significant bit first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cap_fifo.sv
// Synchronous FIFO for captured pixels. Head entry is visible on pop_data
// whenever the FIFO is non-empty (first-word fall-through). A push while
// full is discarded; full is the registered occupancy, so it does not see
// a pop happening in the same cycle.
module cap_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 33
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vid_capture.sv
// Video output capture: samples active-display pixels, buffers them in
// cap_fifo and writes them to a frame store with linear addresses
// (y*H_ACTIVE+x) over a valid/ack handshake.
// Optional: define VID_CAPTURE_CRC_EN to add frame_crc, a CRC-16-CCITT of
// every acked word of the last completed frame.
//
// Handshake: fb_wr is the valid; fb_addr/fb_data are held while fb_wr=1
// and fb_ack=0. A transfer completes in a cycle where fb_wr=1 and fb_ack=1,
// and the next entry may be presented the following cycle. fb_ack is
// ignored while fb_wr=0.
module vid_capture
    import vid_cap_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic [15:0]       VIDOUT,
    input  logic              HBLANK_b,
    input  logic              VBLANK_b,
    input  logic              VSYNC,
    input  logic              arm,
    input  logic              continuous,
    output logic              fb_wr,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_data,
    input  logic              fb_ack,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              overflow,
    output logic              geom_err
`ifdef VID_CAPTURE_CRC_EN
    ,
    output logic [15:0]       frame_crc
`endif
);

    localparam int X_W    = $clog2(H_ACTIVE + 1);
    localparam int Y_W    = $clog2(V_ACTIVE + 1);
    localparam int DATA_W = ADDR_W + 16;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [X_W-1:0]    H_MAX  = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    V_MAX  = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

    cap_state_t        state;
    logic              vsync_q;
    logic              hblank_q;
    logic              vblank_q;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [Y_W-1:0]    y_after;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] line_base;

    logic vsync_rise;
    logic vblank_rise;
    logic vblank_fall;
    logic hblank_fall;
    logic pix_accept;
    logic pix_in_range;
    logic push_req;
    logic line_end;
    logic flush_idle;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    assign vsync_rise   = VSYNC & ~vsync_q;
    assign vblank_rise  = VBLANK_b & ~vblank_q;
    assign vblank_fall  = ~VBLANK_b & vblank_q;
    assign hblank_fall  = ~HBLANK_b & hblank_q;

    assign pix_accept   = (state == ACTIVE) && pix_en && HBLANK_b && VBLANK_b;
    assign pix_in_range = (x < H_MAX) && (y < V_MAX);
    assign push_req     = pix_accept && pix_in_range;
    assign line_end     = (state == ACTIVE) && hblank_fall && (x != '0);
    // y saturates at V_ACTIVE; any extra line only produces dropped pixels.
    assign y_after      = (line_end && (y != V_MAX)) ? y + 1'b1 : y;

    // Nothing left once the FIFO is empty and any presented word is acked now.
    assign flush_idle   = (fifo_count == '0) && (!fb_wr || fb_ack);
    assign fifo_pop     = !fifo_empty && (!fb_wr || fb_ack);

    assign busy         = (state != IDLE);

    cap_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_req),
        .push_data  ({addr, VIDOUT}),
        .pop        (fifo_pop),
        .pop_data   (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Capture FSM with position/address tracking and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            hblank_q   <= 1'b0;
            vblank_q   <= 1'b0;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            line_base  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            overflow   <= 1'b0;
            geom_err   <= 1'b0;
        end else begin
            vsync_q    <= VSYNC;
            hblank_q   <= HBLANK_b;
            vblank_q   <= VBLANK_b;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state    <= SYNC;
                        overflow <= 1'b0;
                        geom_err <= 1'b0;
                    end
                end
                SYNC: begin
                    if (vsync_rise) begin
                        state <= WAIT_VIS;
                    end
                end
                WAIT_VIS: begin
                    x         <= '0;
                    y         <= '0;
                    addr      <= '0;
                    line_base <= '0;
                    if (vblank_rise) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Position advances even when the FIFO drops the pixel.
                    if (push_req) begin
                        x    <= x + 1'b1;
                        addr <= addr + 1'b1;
                        if (fifo_full) begin
                            overflow <= 1'b1;
                        end
                    end else if (pix_accept) begin
                        geom_err <= 1'b1;
                    end
                    if (line_end) begin
                        if (x != H_MAX) begin
                            geom_err <= 1'b1;
                        end
                        x         <= '0;
                        y         <= y_after;
                        line_base <= line_base + H_STEP;
                        addr      <= line_base + H_STEP;
                    end
                    if (vblank_fall) begin
                        if (y_after != V_MAX) begin
                            geom_err <= 1'b1;
                        end
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_idle) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 1'b1;
                        state      <= continuous ? SYNC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: loads the FIFO head whenever the slot is free or acked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_wr   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else if (fifo_pop) begin
            fb_wr              <= 1'b1;
            {fb_addr, fb_data} <= fifo_head;
        end else if (fb_ack) begin
            fb_wr <= 1'b0;
        end
    end

`ifdef VID_CAPTURE_CRC_EN
    logic [15:0] crc_acc;
    logic [15:0] crc_next;

    // Running CRC including a transfer completing this cycle.
    always_comb begin
        crc_next = crc_acc;
        if (fb_wr && fb_ack) begin
            crc_next = crc16_step(crc_acc, fb_data);
        end
    end

    // Restart per frame; publish the final value together with frame_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_acc   <= CRC_INIT;
            frame_crc <= '0;
        end else begin
            if (state == WAIT_VIS) begin
                crc_acc <= CRC_INIT;
            end else begin
                crc_acc <= crc_next;
            end
            if ((state == FLUSH) && flush_idle) begin
                frame_crc <= crc_next;
            end
        end
    end
`endif

endmodule

// File: doc/vid_capture.md
Name: vid_capture

Overview:
- Sink end of the graphics video output. Samples VIDOUT during active display, using the sync generator's blanking and sync signals.
- Buffers pixels in a small FIFO and writes them to an external frame store over a valid/ack handshake, giving linear addresses.
- Used by the graphics bench and by on-board debug to capture whole frames for comparison with golden images.

Parameters:
- H_ACTIVE, 336, active pixels per line.
- V_ACTIVE, 240, active lines per frame.
- FIFO_DEPTH, 8, pixel FIFO entries; must be a power of 2, minimum 2.
- ADDR_W, 17, frame store word address width; must be ≥ clog2(H_ACTIVE*V_ACTIVE).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_en  in  1  one-clk strobe per pixel period, synchronous to clk (MCKR-rate qualifier).
- VIDOUT  in  16  pixel value.
- HBLANK_b  in  1  low during horizontal blank.
- VBLANK_b  in  1  low during vertical blank.
- VSYNC  in  1  vertical sync, active high.
- arm  in  1  one-clk pulse; requests capture of the next full frame.
- continuous  in  1  when 1, re-arms automatically after each frame.
- fb_wr  out  1  write request.
- fb_addr  out  ADDR_W  word address, y*H_ACTIVE+x.
- fb_data  out  16  pixel data.
- fb_ack  in  1  frame store accepts the write this cycle.
- busy  out  1  capture in progress (any state other than IDLE).
- frame_done  out  1  one-clk pulse when the last pixel of a frame has been acked.
- frame_cnt  out  8  completed frames; wraps 255 to 0.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- geom_err  out  1  sticky: line or frame size did not match H_ACTIVE/V_ACTIVE.

Behaviour:
- Reset: state IDLE, FIFO empty, x=y=0. fb_wr, fb_addr, fb_data, busy, frame_done, frame_cnt, overflow and geom_err are all 0.
- State machine:
  - IDLE: on arm, go to SYNC; clear overflow and geom_err.
  - SYNC: wait for a VSYNC rising edge (registered previous value), then go to WAIT_VIS.
  - WAIT_VIS: wait for VBLANK_b to rise; x=y=0; go to ACTIVE.
  - ACTIVE: capture pixels. On a VBLANK_b falling edge go to FLUSH; if y≠V_ACTIVE at that point, set geom_err.
  - FLUSH: when the FIFO is empty and no write is outstanding, pulse frame_done, increment frame_cnt, then go to SYNC if continuous=1, otherwise IDLE.
- arm while busy is ignored.
- Pixel accept rule, evaluated in ACTIVE:
  - A pixel is accepted when pix_en=1, HBLANK_b=1 and VBLANK_b=1.
  - If x<H_ACTIVE and y<V_ACTIVE, push {addr, VIDOUT}, then x++.
  - Otherwise drop the pixel and set geom_err.
- Line end: on a HBLANK_b falling edge in ACTIVE with x>0:
  - If x≠H_ACTIVE, set geom_err.
  - Then y++ and x=0.
- Address arithmetic:
  - Keep a running address register: +1 per push, reset to 0 in WAIT_VIS.
  - At each line end, load y_new*H_ACTIVE via a running line base (+H_ACTIVE); no multiplier.
- FIFO full rule:
  - Fullness is sampled before the same-cycle pop, so a push onto a full FIFO is dropped even if a pop happens that cycle.
  - A dropped push sets overflow; x and the address still advance, so later pixels keep their correct positions.
- Write handshake:
  - fb_wr asserts the cycle after the FIFO becomes non-empty.
  - fb_addr and fb_data stay stable while fb_wr=1 and fb_ack=0.
  - When fb_wr and fb_ack are both 1, that transfer completes. The next entry may be presented in the following cycle; throughput is 1 per clk.
- fb_ack while fb_wr=0 is ignored.
- Asynchronous reset mid-frame aborts immediately: the FIFO is discarded and fb_wr drops.

Optional Feature:
- Macro: VID_CAPTURE_CRC_EN.
- When defined:
  - Adds output frame_crc[15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF), MSB-first, over the fb_data of each acked write in a frame.
  - The value is latched when frame_done pulses and holds until the next frame_done; it is reset to 0.
- When undefined: the port and logic are absent.

Decomposition:
- Package vid_cap_pkg holds:
  - the state enum (IDLE, SYNC, WAIT_VIS, ACTIVE, FLUSH);
  - default constants H_ACTIVE_DEF and V_ACTIVE_DEF;
  - the CRC polynomial/init constants and the crc16_step function.
- Sub-module cap_fifo: synchronous FIFO (parameters FIFO_DEPTH and data width) with push, pop, full, empty, and count of clog2(FIFO_DEPTH)+1 bits.
- vid_capture instantiates cap_fifo once.

Test Plan:
- Nominal frame: arm, then 336x240 ramp pixels (data = addr[15:0]), fb_ack tied 1. Required: 80640 writes with addr 0..80639 in order, data equal to addr, one frame_done pulse, frame_cnt=1, overflow=0, geom_err=0, back to IDLE.
- Backpressure: fb_ack low 20 clks at pixel 100 with FIFO_DEPTH=8 and pix_en every clk. Required: overflow=1; pixels 108..~120 missing from the write stream; the first write after the gap still has the correct address; no duplicate addresses.
- Short line: line 5 has only 300 active pixels. Required: geom_err=1; line 6 starts at addr 6*336=2016.
- Continuous mode: continuous=1, three frames. Required: three frame_done pulses and frame_cnt=3; arm pulses during capture are ignored.
- Reset mid-frame: reset at pixel 5000. Required: fb_wr=0 immediately, all outputs at reset values; a fresh arm then captures a complete frame starting at addr 0.
- CRC (with VID_CAPTURE_CRC_EN): all-zero frame. Required: frame_crc equals the golden CRC of 80640 zero words from the bench model; it holds until the next frame_done.
